eth_tx_arbiter: RTL

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter.sv | 74 +++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: merges two AXI-Stream frame sources onto one TX stream, whole frames at a time,
// with round-robin or fixed-priority selection and an optional inter-frame gap.
module eth_tx_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int IFG_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  s_axis_a_tdata,
  input  logic        s_axis_a_tkeep,
  input  logic        s_axis_a_tlast,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [7:0]  s_axis_b_tdata,
  input  logic        s_axis_b_tkeep,
  input  logic        s_axis_b_tlast,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [1:0]  grant,
  output logic [31:0] frames_a,
  output logic [31:0] frames_b
);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
  logic [1:0] state;
  logic       last_b;
  logic [7:0] gap_cnt;
  logic       send, sel_a, pick_a, frame_done;
  always_comb begin
    send = state == SEND;
    sel_a = grant[0];
    // last_b set means B owned the previous grant, so A takes a tie
    pick_a = PRIORITY_MODE != 0 ? s_axis_a_tvalid : s_axis_a_tvalid & (~s_axis_b_tvalid | last_b);
    m_axis_tvalid = send & (sel_a ? s_axis_a_tvalid : s_axis_b_tvalid);
    m_axis_tdata = send ? (sel_a ? s_axis_a_tdata : s_axis_b_tdata) : 8'd0;
    m_axis_tkeep = send & (sel_a ? s_axis_a_tkeep : s_axis_b_tkeep);
    m_axis_tlast = send & (sel_a ? s_axis_a_tlast : s_axis_b_tlast);
    s_axis_a_tready = send & grant[0] & m_axis_tready;
    s_axis_b_tready = send & grant[1] & m_axis_tready;
    frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      last_b <= 1'b1;
      gap_cnt <= 8'd0;
      frames_a <= 32'd0;
      frames_b <= 32'd0;
    end else if (state == IDLE) begin
      if (enable & (s_axis_a_tvalid | s_axis_b_tvalid)) begin
        state <= SEND;
        grant <= pick_a ? 2'b01 : 2'b10;
        last_b <= ~pick_a;
      end
    end else if (send) begin
      if (frame_done) begin
        if (sel_a) frames_a <= frames_a + 32'd1;
        else frames_b <= frames_b + 32'd1;
        grant <= 2'b00;
        gap_cnt <= 8'd0;
        state <= IFG_CYCLES > 0 ? GAP : IDLE;
      end
    end else begin
      state <= gap_cnt == 8'(IFG_CYCLES - 1) ? IDLE : GAP;
      gap_cnt <= gap_cnt + 8'd1;
    end
  end
endmodule
